// File: rtl/psa_simd_pipe.sv
// psa_simd_pipe: two-stage packed-SIMD add/sub with per-lane overflow and valid/ready flow control.
// Define PSA_SAT_EN to build per-lane saturation selected by op[1]; otherwise results always wrap.
module psa_simd_pipe #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DATA_W-1:0]        i_a,
  input  logic [DATA_W-1:0]        i_b,
  input  logic [1:0]               i_op,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_sum,
  output logic [DATA_W/LANE_W-1:0] o_lane_ovf,
  output logic                     o_error,
  input  logic                     i_clr_err,
  output logic                     o_err_sticky,
  output logic [15:0]              o_xfer_cnt
);

  localparam int LANES = DATA_W / LANE_W;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic              r_s1_sub;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_sum;
  logic [LANES-1:0]  r_s2_ovf;
  logic              r_err_sticky;
  logic [15:0]       r_xfer_cnt;

  logic              w_s2_adv;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_s2_error;
  logic [DATA_W-1:0] w_res;
  logic [LANES-1:0]  w_ovf;

  assign w_s2_adv   = !r_s2_valid || i_out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_xfer     = r_s2_valid && i_out_ready;
  assign w_s2_error = |r_s2_ovf;

`ifdef PSA_SAT_EN
  logic r_s1_sat;
`else
  logic w_unused_op_sat;
  assign w_unused_op_sat = i_op[1];
`endif

  // Each lane is computed in isolation, so no carry or borrow can leak into its neighbour.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] w_la;
    logic [LANE_W-1:0] w_lb;
    logic [LANE_W-1:0] w_lr;
    logic              w_sa;
    logic              w_sb;

    assign w_la = r_s1_a[g*LANE_W +: LANE_W];
    assign w_lb = r_s1_b[g*LANE_W +: LANE_W];
    assign w_lr = r_s1_sub ? (w_la - w_lb) : (w_la + w_lb);
    assign w_sa = w_la[LANE_W-1];
    assign w_sb = w_lb[LANE_W-1];

    assign w_ovf[g] = (r_s1_sub ? (w_sa != w_sb) : (w_sa == w_sb)) &&
                      (w_lr[LANE_W-1] != w_sa);

`ifdef PSA_SAT_EN
    // On overflow the true result lies beyond the limit on a's side of zero.
    assign w_res[g*LANE_W +: LANE_W] = (r_s1_sat && w_ovf[g]) ?
                                       {w_sa, {(LANE_W-1){~w_sa}}} : w_lr;
`else
    assign w_res[g*LANE_W +: LANE_W] = w_lr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= i_in_valid;
    end
  end

  // Operand payload needs no reset: it is only consumed while r_s1_valid is set.
  always_ff @(posedge clk) begin
    if (w_in_ready && i_in_valid) begin
      r_s1_a   <= i_a;
      r_s1_b   <= i_b;
      r_s1_sub <= i_op[0];
`ifdef PSA_SAT_EN
      r_s1_sat <= i_op[1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_ovf   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum <= w_res;
        r_s2_ovf <= w_ovf;
      end
    end
  end

  // A fresh error transfer wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_xfer_cnt   <= '0;
    end else begin
      r_err_sticky <= (r_err_sticky && !i_clr_err) || (w_xfer && w_s2_error);
      if (w_xfer && (r_xfer_cnt != 16'hFFFF)) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_s2_valid;
  assign o_sum        = r_s2_sum;
  assign o_lane_ovf   = r_s2_ovf;
  assign o_error      = w_s2_error;
  assign o_err_sticky = r_err_sticky;
  assign o_xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_psa_simd_pipe.sv
// tb_psa_simd_pipe: directed and random checks of psa_simd_pipe with 4-bit and 8-bit lanes.
// Expected saturated values follow PSA_SAT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_psa_simd_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, outReady, clrErr;
  logic [15:0] opA, opB;
  logic [1:0]  opSel;

  logic        inReady4, outValid4, error4, sticky4;
  logic [15:0] sum4, xfer4;
  logic [3:0]  ovf4;
  logic        inReady8, outValid8, error8, sticky8;
  logic [15:0] sum8, xfer8;
  logic [1:0]  ovf8;

  int nVec = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  psa_simd_pipe #(.DATA_W(16), .LANE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(inValid), .o_in_ready(inReady4),
    .i_a(opA), .i_b(opB), .i_op(opSel), .o_out_valid(outValid4), .i_out_ready(outReady),
    .o_sum(sum4), .o_lane_ovf(ovf4), .o_error(error4), .i_clr_err(clrErr),
    .o_err_sticky(sticky4), .o_xfer_cnt(xfer4)
  );

  psa_simd_pipe #(.DATA_W(16), .LANE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(inValid), .o_in_ready(inReady8),
    .i_a(opA), .i_b(opB), .i_op(opSel), .o_out_valid(outValid8), .i_out_ready(outReady),
    .o_sum(sum8), .o_lane_ovf(ovf8), .o_error(error8), .i_clr_err(clrErr),
    .o_err_sticky(sticky8), .o_xfer_cnt(xfer8)
  );

  // Reference lane arithmetic done on signed integers and range-checked against the lane limits.
  function automatic void model(input int lw, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] op, output logic [15:0] s, output logic [3:0] v);
    int half, mask, la, lb, t, r;
    half = 1 << (lw - 1);
    mask = (2 * half) - 1;
    s = '0;
    v = '0;
    for (int i = 0; i < 16 / lw; i++) begin
      la = int'(a >> (i * lw)) & mask;
      lb = int'(b >> (i * lw)) & mask;
      if (la >= half) la = la - 2 * half;
      if (lb >= half) lb = lb - 2 * half;
      t = op[0] ? (la - lb) : (la + lb);
      v[i] = (t >= half) || (t < -half);
      r = t & mask;
`ifdef PSA_SAT_EN
      if (op[1] && v[i]) r = (t >= half) ? (half - 1) : half;
`endif
      s = s | 16'(r << (i * lw));
    end
  endfunction

  // Sends one beat into an empty pipe and samples both DUTs while the result is presented.
  task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          output logic [15:0] s4, output logic [3:0] v4, output logic e4,
                          output logic [15:0] s8, output logic [1:0] v8, output logic seen);
    s4 = 'x; v4 = 'x; e4 = 'x; s8 = 'x; v8 = 'x;
    seen = 1'b0;
    @(negedge clk);
    opA = a; opB = b; opSel = op; inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (outValid4 && outValid8) begin
        seen = 1'b1;
        s4 = sum4; v4 = ovf4; e4 = error4; s8 = sum8; v8 = ovf8;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inValid = 1'b0; outReady = 1'b0; clrErr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    nVec++; if (outValid4 !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid4); end
    nVec++; if (sum4 !== 16'h0) begin nMiss++; $display("[TB] FAIL reset_sum got=%h exp=0000", sum4); end
    nVec++; if (ovf4 !== 4'b0) begin nMiss++; $display("[TB] FAIL reset_lane_ovf got=%b exp=0000", ovf4); end
    nVec++; if (error4 !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_error got=%b exp=0", error4); end
    nVec++; if (sticky4 !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_err_sticky got=%b exp=0", sticky4); end
    nVec++; if (xfer4 !== 16'h0) begin nMiss++; $display("[TB] FAIL reset_xfer_cnt got=%h exp=0000", xfer4); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    nVec++; if (inReady4 !== 1'b1) begin nMiss++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady4); end
    nVec++; if (outValid4 !== 1'b0) begin nMiss++; $display("[TB] FAIL empty_out_valid got=%b exp=0", outValid4); end
  endtask

  task automatic test_basic();
    logic [15:0] vA[8], vB[8], vSum[8];
    logic [1:0]  vOp[8];
    logic [3:0]  vOvf[8];
    logic [15:0] s4, s8;
    logic [3:0]  v4;
    logic [1:0]  v8;
    logic        e4, seen;
    vA   = '{16'h7342, 16'h7342, 16'h8000, 16'h8000, 16'h0FFF, 16'h0123, 16'h0008, 16'h0007};
    vB   = '{16'h1111, 16'h1111, 16'h1000, 16'h1000, 16'h0001, 16'h0321, 16'h0008, 16'h0008};
    vOp  = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    vOvf = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
`ifdef PSA_SAT_EN
    vSum = '{16'h8453, 16'h7453, 16'h7000, 16'h8000, 16'h0FF0, 16'h0E02, 16'h0008, 16'h0007};
`else
    vSum = '{16'h8453, 16'h8453, 16'h7000, 16'h7000, 16'h0FF0, 16'h0E02, 16'h0000, 16'h000F};
`endif
    for (int i = 0; i < 8; i++) begin
      run_beat(vA[i], vB[i], vOp[i], s4, v4, e4, s8, v8, seen);
      nVec++;
      if (!seen) begin
        nMiss++; $display("[TB] FAIL basic%0d_timeout got=no_out_valid exp=out_valid", i);
      end else begin
        if (s4 !== vSum[i]) begin nMiss++; $display("[TB] FAIL basic%0d_sum got=%h exp=%h", i, s4, vSum[i]); end
        nVec++;
        if (v4 !== vOvf[i]) begin nMiss++; $display("[TB] FAIL basic%0d_lane_ovf got=%b exp=%b", i, v4, vOvf[i]); end
        nVec++;
        if (e4 !== (|vOvf[i])) begin nMiss++; $display("[TB] FAIL basic%0d_error got=%b exp=%b", i, e4, |vOvf[i]); end
      end
    end
  endtask

  task automatic test_lane8();
    logic [15:0] s4, s8, expSat;
    logic [3:0]  v4;
    logic [1:0]  v8;
    logic        e4, seen;
    run_beat(16'h7F01, 16'h0101, 2'b00, s4, v4, e4, s8, v8, seen);
    nVec++; if (!seen || s8 !== 16'h8002) begin nMiss++; $display("[TB] FAIL lane8_sum got=%h exp=8002", s8); end
    nVec++; if (!seen || v8 !== 2'b10) begin nMiss++; $display("[TB] FAIL lane8_ovf got=%b exp=10", v8); end
`ifdef PSA_SAT_EN
    expSat = 16'h7F02;
`else
    expSat = 16'h8002;
`endif
    run_beat(16'h7F01, 16'h0101, 2'b10, s4, v4, e4, s8, v8, seen);
    nVec++; if (!seen || s8 !== expSat) begin nMiss++; $display("[TB] FAIL lane8_sat_sum got=%h exp=%h", s8, expSat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bA[4], bB[4], bExp[4];
    logic [1:0]  bOp[4];
    logic [15:0] held;
    int accepted, got, lastCyc, idx;
    bA   = '{16'h1234, 16'h7342, 16'h0FFF, 16'h8000};
    bB   = '{16'h1111, 16'h1111, 16'h0001, 16'h1000};
    bOp  = '{2'b00, 2'b00, 2'b00, 2'b01};
    bExp = '{16'h2345, 16'h8453, 16'h0FF0, 16'h7000};
    pulse_reset();
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idx = (accepted < 4) ? accepted : 0;
      inValid = (accepted < 4); opA = bA[idx]; opB = bB[idx]; opSel = bOp[idx]; outReady = 1'b0;
      #1;
      if (inValid && inReady4) accepted++;
    end
    nVec++; if (accepted != 2) begin nMiss++; $display("[TB] FAIL b2b_accepted got=%0d exp=2", accepted); end
    nVec++; if (inReady4 !== 1'b0) begin nMiss++; $display("[TB] FAIL b2b_full_in_ready got=%b exp=0", inReady4); end
    held = sum4;
    @(negedge clk);
    #1;
    nVec++; if (outValid4 !== 1'b1) begin nMiss++; $display("[TB] FAIL b2b_stall_out_valid got=%b exp=1", outValid4); end
    nVec++; if (sum4 !== bExp[0] || sum4 !== held) begin nMiss++; $display("[TB] FAIL b2b_stall_sum got=%h exp=%h", sum4, bExp[0]); end
    nVec++; if (inReady4 !== 1'b0) begin nMiss++; $display("[TB] FAIL b2b_still_full got=%b exp=0", inReady4); end
    got = 0;
    lastCyc = -1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      idx = (accepted < 4) ? accepted : 0;
      inValid = (accepted < 4); opA = bA[idx]; opB = bB[idx]; opSel = bOp[idx]; outReady = 1'b1;
      #1;
      if (outValid4) begin
        nVec++;
        if (sum4 !== bExp[got]) begin nMiss++; $display("[TB] FAIL b2b_order%0d got=%h exp=%h", got, sum4, bExp[got]); end
        if (got > 0) begin
          nVec++;
          if (c != lastCyc + 1) begin nMiss++; $display("[TB] FAIL b2b_rate%0d got=gap%0d exp=gap1", got, c - lastCyc); end
        end
        lastCyc = c;
        got++;
      end
      if (inValid && inReady4) accepted++;
      @(negedge clk);
    end
    inValid = 1'b0;
    nVec++; if (got != 4) begin nMiss++; $display("[TB] FAIL b2b_drain_timeout got=%0d exp=4", got); end
    #1;
    nVec++; if (xfer4 !== 16'd4) begin nMiss++; $display("[TB] FAIL b2b_xfer_cnt got=%0d exp=4", xfer4); end
    nVec++; if (outValid4 !== 1'b0) begin nMiss++; $display("[TB] FAIL b2b_empty got=%b exp=0", outValid4); end
  endtask

  task automatic test_sticky();
    pulse_reset();
    #1;
    nVec++; if (sticky4 !== 1'b0) begin nMiss++; $display("[TB] FAIL sticky_initial got=%b exp=0", sticky4); end
    @(negedge clk);
    opA = 16'h7342; opB = 16'h1111; opSel = 2'b00; inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    #1;
    nVec++; if (outValid4 !== 1'b1 || error4 !== 1'b1) begin nMiss++; $display("[TB] FAIL sticky_err_beat got=%b%b exp=11", outValid4, error4); end
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    #1;
    nVec++; if (sticky4 !== 1'b1) begin nMiss++; $display("[TB] FAIL sticky_set_with_clr got=%b exp=1", sticky4); end
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    #1;
    nVec++; if (sticky4 !== 1'b0) begin nMiss++; $display("[TB] FAIL sticky_clear got=%b exp=0", sticky4); end
    nVec++; if (xfer4 !== 16'd1) begin nMiss++; $display("[TB] FAIL sticky_xfer_cnt got=%0d exp=1", xfer4); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] s4, s8;
    logic [3:0]  v4;
    logic [1:0]  v8;
    logic        e4, seen, stale;
    run_beat(16'h7342, 16'h1111, 2'b00, s4, v4, e4, s8, v8, seen);
    @(negedge clk);
    nVec++; if (sticky4 !== 1'b1) begin nMiss++; $display("[TB] FAIL mid_sticky_before got=%b exp=1", sticky4); end
    opA = 16'h0008; opB = 16'h0008; opSel = 2'b00; inValid = 1'b1; outReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    inValid = 1'b0;
    #1;
    nVec++; if (outValid4 !== 1'b1 || inReady4 !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_full got=%b%b exp=10", outValid4, inReady4); end
    rst_n = 1'b0;
    #1;
    nVec++; if (outValid4 !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_out_valid got=%b exp=0", outValid4); end
    nVec++; if (sticky4 !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_err_sticky got=%b exp=0", sticky4); end
    nVec++; if (xfer4 !== 16'h0) begin nMiss++; $display("[TB] FAIL mid_xfer_cnt got=%0d exp=0", xfer4); end
    nVec++; if (inReady4 !== 1'b1) begin nMiss++; $display("[TB] FAIL mid_in_ready got=%b exp=1", inReady4); end
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (outValid4 || outValid8) stale = 1'b1;
    end
    nVec++; if (stale !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_stale_beat got=%b exp=0", stale); end
    nVec++; if (xfer4 !== 16'h0) begin nMiss++; $display("[TB] FAIL mid_xfer_after got=%0d exp=0", xfer4); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s4, s8, m4, m8;
    logic [1:0]  op, v8;
    logic [3:0]  v4, mv4, mv8;
    logic        e4, seen;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      model(4, a, b, op, m4, mv4);
      model(8, a, b, op, m8, mv8);
      run_beat(a, b, op, s4, v4, e4, s8, v8, seen);
      nVec++;
      if (!seen || s4 !== m4 || v4 !== mv4) begin
        nMiss++; $display("[TB] FAIL rand4_%0d a=%h b=%h op=%b got=%h/%b exp=%h/%b", i, a, b, op, s4, v4, m4, mv4);
      end
      nVec++;
      if (!seen || s8 !== m8 || v8 !== mv8[1:0]) begin
        nMiss++; $display("[TB] FAIL rand8_%0d a=%h b=%h op=%b got=%h/%b exp=%h/%b", i, a, b, op, s8, v8, m8, mv8[1:0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    inValid = 1'b0; outReady = 1'b0; clrErr = 1'b0;
    opA = '0; opB = '0; opSel = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_lane8();
    test_back_to_back();
    test_sticky();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
